ring_host_master: RTL and testbench
===================================

# ring_host_master

Host-side ring agent that closes the tile ring loop. It accepts single RD/WR requests from a host port and injects each one into a free ring slot. It forwards all other ring traffic unchanged and captures the matching RD_RSP/WR_RSP when it returns. It sits between the last tile's RingOutput*Q502H and the first tile's RingInput*Q500H, and drives the same ring the tiles receive.

## Interface
- RSP_TIMEOUT, default 1024: cycles allowed in WAIT_RSP before an error completion (timeout build only).
- QClk  in  1  ring clock.
- RstQnnnH  in  1  reset; one clock, synchronous, active-high.
- HostReqValid  in  1  host request present.
- HostReqReady  out  1  request accepted this cycle (valid & ready).
- HostReqOpcode  in  t_opcode  RD or WR only.
- HostReqAddress  in  32  target address; [31:24] = target CoreID.
- HostReqData  in  32  write data; ignored for RD.
- HostRspValid  out  1  one-cycle completion pulse.
- HostRspData  out  32  read data; 0 for WR completions.
- HostRspError  out  1  completion was a timeout.
- RingInputValidQ502H / RingInputOpcodeQ502H / RingInputAddressQ502H / RingInputDataQ502H  in  1/t_opcode/32/32  ring traffic from the last tile.
- RingOutputValidQ500H / RingOutputOpcodeQ500H / RingOutputAddressQ500H / RingOutputDataQ500H  out  1/t_opcode/32/32  ring traffic to the first tile; registered.

## Operation
- FSM states: IDLE, WAIT_SLOT, WAIT_RSP.
- IDLE: HostReqReady=1. On HostReqValid, latch opcode, address and data, then go to WAIT_SLOT. At most one outstanding request.
- WAIT_SLOT: HostReqReady=0.
  - Incoming slot invalid: inject the latched request into the output register and go to WAIT_RSP.
  - Incoming slot valid: forward it and stay in WAIT_SLOT.
  - An RD or WR request is injected in the first free slot.
- WAIT_RSP: HostReqReady=0.
  - Match condition: incoming valid, opcode = RD_RSP for a RD or WR_RSP for a WR, and address = latched address.
  - On a match: consume the packet, which becomes an empty output slot (valid 0, opcode RD, address/data 0). Pulse HostRspValid with data = RingInputData for RD and 0 for WR, then go to IDLE.
  - Non-matching packets are forwarded.
- Forwarding: output register <= input fields. When valid=0, output opcode/address/data are forced to RD/0/0.
- A request and a response arriving in the same cycle cannot occur (single outstanding); no arbitration is needed.

## Timing
- Reset values:
  - RingOutputValidQ500H=0, RingOutputOpcodeQ500H=RD, address/data=0.
  - HostReqReady=1 (state IDLE), HostRspValid=0, HostRspData=0, HostRspError=0.
  - Latched request and timeout counter cleared.
- Ring pass-through latency: exactly 1 cycle (Q502H input → Q500H output next edge).
- Accept to injection:
  - Minimum: request accepted at edge N, injected on the output at edge N+2 if the slot at N+1 is empty.
  - One extra cycle per occupied incoming slot.
- Response to completion: HostRspValid asserted the cycle after the matching input is sampled, same edge the empty slot appears on the output.
- Reset mid-operation: the outstanding request is dropped; no HostRspValid; the ring output goes empty the next cycle.

## Configuration
- RING_HOST_MASTER_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to WAIT_RSP and increments each cycle in WAIT_RSP.
  - When it reaches RSP_TIMEOUT-1: HostRspValid=1, HostRspError=1, HostRspData=32'hDEAD_BEEF, then IDLE.
  - A later matching response is then forwarded, not consumed.
- Undefined: no counter; WAIT_RSP waits indefinitely; HostRspError is tied to 0.

## Structure
- lotr_pkg holds:
  - t_opcode with RD=2'b00, RD_RSP=2'b01, WR=2'b10, WR_RSP=2'b11.
  - typedef t_ring_pkt: valid, opcode, address, data.
  - typedef t_host_state enum.
  - HOST_TIMEOUT_DATA constant.
- One natural sub-module: ring_slot_reg, the registered one-slot stage with empty-forcing, shared with tile ring ports.

## Test plan
- Reset held 4 cycles, release → outputs all zero/RD, HostReqReady=1; an idle ring input stays empty at the output for 20 cycles.
- Host WR addr 32'h0200_0001, data 32'h0200_0001, ring empty → injected WR appears 2 cycles after accept. Then drive WR_RSP with the same address → HostRspValid pulse with data 0; the output slot is empty that cycle.
- Host RD addr 32'h0100_0010 while the ring carries 3 back-to-back foreign packets → those forwarded unchanged with 1-cycle latency; injection in the 4th slot. Then RD_RSP with data 32'hCAFE_0001 → HostRspData=32'hCAFE_0001.
- In WAIT_RSP, drive RD_RSP with a different address and a WR_RSP with the same address → both forwarded, no completion, state stays WAIT_RSP.
- Reset asserted one cycle after injection → no HostRspValid, output empty next cycle, HostReqReady=1 after release.
- RING_HOST_MASTER_TIMEOUT_EN with RSP_TIMEOUT=16, no response → HostRspValid and HostRspError with 32'hDEAD_BEEF 16 cycles after entering WAIT_RSP.

Source files
------------

// File: rtl/lotr_pkg.sv
// ----------------------------------------------------------------------------
// lotr_pkg
// Shared types for the tile ring: the opcode encoding, the one-slot ring
// packet, the host-master state encoding and the data word returned on a
// host completion that ended without a response.
//
// Contents
//   t_opcode           RD / RD_RSP / WR / WR_RSP (2 bits)
//   t_ring_pkt         {valid, opcode, address, data}
//   t_host_state       IDLE / WAIT_SLOT / WAIT_RSP
//   HOST_TIMEOUT_DATA  read data reported with an error completion
//   EMPTY_PKT          canonical empty slot (valid 0, RD, 0, 0)
//   rspOpcodeFor()     response opcode that answers a given request opcode
// ----------------------------------------------------------------------------
package lotr_pkg;

   typedef enum logic [1:0] {
      RD     = 2'b00,
      RD_RSP = 2'b01,
      WR     = 2'b10,
      WR_RSP = 2'b11
   } t_opcode;

   typedef struct packed {
      logic        valid;
      t_opcode     opcode;
      logic [31:0] address;
      logic [31:0] data;
   } t_ring_pkt;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_SLOT = 2'd1,
      WAIT_RSP  = 2'd2
   } t_host_state;

   localparam logic [31:0] HOST_TIMEOUT_DATA = 32'hDEAD_BEEF;

   // An empty slot always carries RD/0/0 so that downstream tiles never see
   // stale fields behind a cleared valid bit.
   localparam t_ring_pkt EMPTY_PKT = '{valid: 1'b0, opcode: RD, address: 32'h0, data: 32'h0};

   function automatic t_opcode rspOpcodeFor(input t_opcode reqOpcode);
      return (reqOpcode == WR) ? WR_RSP : RD_RSP;
   endfunction

endpackage

// File: rtl/ring_slot_reg.sv
// ----------------------------------------------------------------------------
// ring_slot_reg
// Registered one-slot ring stage. Whatever is presented on slotIn is captured
// on every clock; a slot with valid=0 is stored as the canonical empty packet
// so opcode/address/data read RD/0/0 whenever the slot is free.
//
// Ports
//   QClk      in   ring clock
//   RstQnnnH  in   synchronous active-high reset, empties the slot
//   slotIn    in   t_ring_pkt  packet to place in the slot next edge
//   slotOut   out  t_ring_pkt  registered slot contents
// ----------------------------------------------------------------------------
module ring_slot_reg
   import lotr_pkg::*;
(
   input  logic      QClk,
   input  logic      RstQnnnH,
   input  t_ring_pkt slotIn,
   output t_ring_pkt slotOut
);

   // NOTE: sequential state is written only with non-blocking assignments so
   // every register samples the pre-edge value of its inputs, regardless of
   // the order the simulator evaluates always blocks.
   always_ff @(posedge QClk) begin
      if (RstQnnnH) begin
         slotOut <= EMPTY_PKT;
      end else if (slotIn.valid) begin
         slotOut <= slotIn;
      end else begin
         slotOut <= EMPTY_PKT;
      end
   end

endmodule

// File: rtl/ring_host_master.sv
// ----------------------------------------------------------------------------
// ring_host_master
// Host-side agent that closes the tile ring. A single RD/WR request from the
// host port is latched, injected into the first free ring slot, and then the
// agent watches the returning traffic for the matching RD_RSP/WR_RSP. The
// matching response is consumed (its slot goes out empty) and reported on the
// host response port one cycle after it is sampled. All other traffic passes
// through with one cycle of latency.
//
// Optional feature (macro RING_HOST_MASTER_TIMEOUT_EN)
//   When defined, a 16-bit counter bounds the wait for a response to
//   RSP_TIMEOUT cycles; on expiry an error completion (data 32'hDEAD_BEEF)
//   is returned and any later response is simply forwarded. When undefined,
//   the agent waits indefinitely and HostRspError is tied low.
//
// Parameters
//   RSP_TIMEOUT              cycles allowed in WAIT_RSP (default 1024);
//                            only used by the timeout build
//
// Ports
//   QClk                     in   ring clock
//   RstQnnnH                 in   synchronous active-high reset
//   HostReqValid             in   host request present
//   HostReqReady             out  agent idle; request accepted when valid
//   HostReqOpcode            in   RD or WR
//   HostReqAddress           in   target address, [31:24] = target CoreID
//   HostReqData              in   write data (ignored for RD)
//   HostRspValid             out  one-cycle completion pulse
//   HostRspData              out  read data, 0 for WR completions
//   HostRspError             out  completion was a timeout
//   RingInput*Q502H          in   ring traffic from the last tile
//   RingOutput*Q500H         out  registered ring traffic to the first tile
// ----------------------------------------------------------------------------
module ring_host_master
   import lotr_pkg::*;
   #(parameter int RSP_TIMEOUT = 1024)
(
   input  logic        QClk,
   input  logic        RstQnnnH,

   input  logic        HostReqValid,
   output logic        HostReqReady,
   input  t_opcode     HostReqOpcode,
   input  logic [31:0] HostReqAddress,
   input  logic [31:0] HostReqData,

   output logic        HostRspValid,
   output logic [31:0] HostRspData,
   output logic        HostRspError,

   input  logic        RingInputValidQ502H,
   input  t_opcode     RingInputOpcodeQ502H,
   input  logic [31:0] RingInputAddressQ502H,
   input  logic [31:0] RingInputDataQ502H,

   output logic        RingOutputValidQ500H,
   output t_opcode     RingOutputOpcodeQ500H,
   output logic [31:0] RingOutputAddressQ500H,
   output logic [31:0] RingOutputDataQ500H
);

   t_host_state state;
   t_host_state stateNext;

   t_ring_pkt   ringIn;
   t_ring_pkt   slotNext;
   t_ring_pkt   slotOut;
   t_ring_pkt   reqQ;

   logic        accept;
   logic        isMatch;

   logic        rspValidNext;
   logic [31:0] rspDataNext;
   logic        rspValidQ;
   logic [31:0] rspDataQ;

   assign ringIn.valid   = RingInputValidQ502H;
   assign ringIn.opcode  = RingInputOpcodeQ502H;
   assign ringIn.address = RingInputAddressQ502H;
   assign ringIn.data    = RingInputDataQ502H;

   assign HostReqReady = (state == IDLE);
   assign accept       = HostReqValid && HostReqReady;

   // Only the response type that answers the outstanding request, addressed
   // to the same location, completes it; everything else keeps circulating.
   assign isMatch = ringIn.valid
                 && (ringIn.opcode == rspOpcodeFor(reqQ.opcode))
                 && (ringIn.address == reqQ.address);

`ifdef RING_HOST_MASTER_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LAST = 16'(RSP_TIMEOUT - 1);

   logic [15:0] waitCnt;
   logic        timeoutHit;
   logic        rspErrorNext;
   logic        rspErrorQ;

   assign timeoutHit = (waitCnt == TIMEOUT_LAST);

   // Counts cycles spent in WAIT_RSP; restarts on the injection edge so the
   // first WAIT_RSP cycle sees zero.
   always_ff @(posedge QClk) begin
      if (RstQnnnH) begin
         waitCnt <= 16'h0;
      end else if ((state == WAIT_SLOT) && (stateNext == WAIT_RSP)) begin
         waitCnt <= 16'h0;
      end else if (state == WAIT_RSP) begin
         waitCnt <= waitCnt + 16'h1;
      end
   end
`endif

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge QClk) begin
      if (RstQnnnH) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Latched host request; valid is forced high so the packet can be dropped
   // straight into the output slot on injection.
   always_ff @(posedge QClk) begin
      if (RstQnnnH) begin
         reqQ <= EMPTY_PKT;
      end else if (accept) begin
         reqQ <= '{valid: 1'b1, opcode: HostReqOpcode,
                   address: HostReqAddress, data: HostReqData};
      end
   end

   // -------------------------------------------------------------------------
   // Next state, next ring slot, next host completion
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default before the case so no
      // path leaves a signal unassigned, which would infer a latch.
      stateNext    = state;
      slotNext     = ringIn;
      rspValidNext = 1'b0;
      rspDataNext  = 32'h0;
`ifdef RING_HOST_MASTER_TIMEOUT_EN
      rspErrorNext = 1'b0;
`endif

      unique case (state)
         IDLE: begin
            if (HostReqValid) begin
               stateNext = WAIT_SLOT;
            end
         end

         WAIT_SLOT: begin
            // Occupied slots pass through; the first free one carries the
            // request.
            if (!ringIn.valid) begin
               slotNext  = reqQ;
               stateNext = WAIT_RSP;
            end
         end

         WAIT_RSP: begin
            if (isMatch) begin
               slotNext     = EMPTY_PKT;
               rspValidNext = 1'b1;
               rspDataNext  = (reqQ.opcode == RD) ? ringIn.data : 32'h0;
               stateNext    = IDLE;
            end
`ifdef RING_HOST_MASTER_TIMEOUT_EN
            // A genuine response in the last allowed cycle still wins.
            else if (timeoutHit) begin
               rspValidNext = 1'b1;
               rspDataNext  = HOST_TIMEOUT_DATA;
               rspErrorNext = 1'b1;
               stateNext    = IDLE;
            end
`endif
         end

         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Completion is registered so it lines up with the empty slot that
   // replaces the consumed response on the ring output.
   always_ff @(posedge QClk) begin
      if (RstQnnnH) begin
         rspValidQ <= 1'b0;
         rspDataQ  <= 32'h0;
      end else begin
         rspValidQ <= rspValidNext;
         rspDataQ  <= rspDataNext;
      end
   end

`ifdef RING_HOST_MASTER_TIMEOUT_EN
   always_ff @(posedge QClk) begin
      if (RstQnnnH) begin
         rspErrorQ <= 1'b0;
      end else begin
         rspErrorQ <= rspErrorNext;
      end
   end

   assign HostRspError = rspErrorQ;
`else
   assign HostRspError = 1'b0;
`endif

   assign HostRspValid = rspValidQ;
   assign HostRspData  = rspDataQ;

   // -------------------------------------------------------------------------
   // Output slot register
   // -------------------------------------------------------------------------
   ring_slot_reg slotReg (
      .QClk     (QClk),
      .RstQnnnH (RstQnnnH),
      .slotIn   (slotNext),
      .slotOut  (slotOut)
   );

   assign RingOutputValidQ500H   = slotOut.valid;
   assign RingOutputOpcodeQ500H  = slotOut.opcode;
   assign RingOutputAddressQ500H = slotOut.address;
   assign RingOutputDataQ500H    = slotOut.data;

endmodule

// File: tb/tb_ring_host_master.sv
// ----------------------------------------------------------------------------
// tb_ring_host_master
// Scoreboard bench for ring_host_master. Each driven cycle runs a reference
// model of the host agent's rules and queues the outputs expected after the
// next clock edge; an independent monitor pops and compares on the falling
// edge. Directed scenarios are followed by randomized traffic.
// Define RING_HOST_MASTER_TIMEOUT_EN to exercise the timeout build
// (RSP_TIMEOUT = 16).
// ----------------------------------------------------------------------------
module tb_ring_host_master;
   import lotr_pkg::*;

   localparam int TB_TIMEOUT = 16;

   logic        clk;
   logic        rst;
   logic        hostValid;
   logic        hostReady;
   t_opcode     hostOp;
   logic [31:0] hostAddr;
   logic [31:0] hostData;
   logic        rspValid;
   logic [31:0] rspData;
   logic        rspError;
   t_ring_pkt   ringIn;
   logic        outValid;
   t_opcode     outOp;
   logic [31:0] outAddr;
   logic [31:0] outData;

   ring_host_master #(.RSP_TIMEOUT(TB_TIMEOUT)) dut (
      .QClk                   (clk),
      .RstQnnnH               (rst),
      .HostReqValid           (hostValid),
      .HostReqReady           (hostReady),
      .HostReqOpcode          (hostOp),
      .HostReqAddress         (hostAddr),
      .HostReqData            (hostData),
      .HostRspValid           (rspValid),
      .HostRspData            (rspData),
      .HostRspError           (rspError),
      .RingInputValidQ502H    (ringIn.valid),
      .RingInputOpcodeQ502H   (ringIn.opcode),
      .RingInputAddressQ502H  (ringIn.address),
      .RingInputDataQ502H     (ringIn.data),
      .RingOutputValidQ500H   (outValid),
      .RingOutputOpcodeQ500H  (outOp),
      .RingOutputAddressQ500H (outAddr),
      .RingOutputDataQ500H    (outData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // -------------------------------------------------------------------------
   // Scoreboard
   // -------------------------------------------------------------------------
   typedef struct {
      int          due;
      t_ring_pkt   ring;
      logic        rspValid;
      logic [31:0] rspData;
      logic        rspError;
      logic        ready;
   } t_exp;

   t_exp expQ[$];
   int   vectors     = 0;
   int   miscompares = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic t_ring_pkt mkPkt(input logic v, input t_opcode op,
                                       input logic [31:0] a, input logic [31:0] d);
      t_ring_pkt p;
      p.valid = v; p.opcode = op; p.address = a; p.data = d;
      return p;
   endfunction

   // Free slot with junk in the payload fields, to prove the output scrubs them.
   function automatic t_ring_pkt junkEmpty();
      return mkPkt(1'b0, t_opcode'($urandom_range(0, 3)), $urandom, $urandom);
   endfunction

   t_exp      monE;
   t_ring_pkt monOut;
   always @(negedge clk) begin
      if (expQ.size() > 0 && expQ[0].due == cyc) begin
         monE   = expQ.pop_front();
         monOut = mkPkt(outValid, outOp, outAddr, outData);
         check("ring_out", 128'(monOut), 128'(monE.ring));
         check("rsp_valid", 128'(rspValid), 128'(monE.rspValid));
         check("req_ready", 128'(hostReady), 128'(monE.ready));
         if (monE.rspValid) begin
            check("rsp_data", 128'(rspData), 128'(monE.rspData));
            check("rsp_error", 128'(rspError), 128'(monE.rspError));
         end
      end
   end

   // -------------------------------------------------------------------------
   // Reference model: one outstanding host request that is waiting either
   // for a free slot or for its answer.
   // -------------------------------------------------------------------------
   logic        mPending  = 1'b0;
   logic        mInjected = 1'b0;
   t_opcode     mOp       = RD;
   logic [31:0] mAddr     = 32'h0;
   logic [31:0] mData     = 32'h0;
   int          mInjEdge  = 0;

   task automatic step(input logic r, input logic hv, input t_opcode op,
                       input logic [31:0] a, input logic [31:0] d, input t_ring_pkt pin);
      t_exp      e;
      t_ring_pkt empty;
      t_opcode   wantRsp;
      empty = mkPkt(1'b0, RD, 32'h0, 32'h0);
      rst = r; hostValid = hv; hostOp = op; hostAddr = a; hostData = d; ringIn = pin;

      e.due      = cyc + 1;
      e.ring     = pin.valid ? pin : empty;
      e.rspValid = 1'b0;
      e.rspData  = 32'h0;
      e.rspError = 1'b0;

      if (r) begin
         mPending  = 1'b0;
         mInjected = 1'b0;
         e.ring    = empty;
      end else if (!mPending) begin
         if (hv) begin
            mPending = 1'b1; mInjected = 1'b0;
            mOp = op; mAddr = a; mData = d;
         end
      end else if (!mInjected) begin
         if (!pin.valid) begin
            e.ring    = mkPkt(1'b1, mOp, mAddr, mData);
            mInjected = 1'b1;
            mInjEdge  = cyc + 1;
         end
      end else begin
         wantRsp = (mOp == WR) ? WR_RSP : RD_RSP;
         if (pin.valid && pin.opcode == wantRsp && pin.address == mAddr) begin
            e.ring     = empty;
            e.rspValid = 1'b1;
            e.rspData  = (mOp == RD) ? pin.data : 32'h0;
            mPending   = 1'b0;
         end
`ifdef RING_HOST_MASTER_TIMEOUT_EN
         else if ((cyc + 1) - mInjEdge == TB_TIMEOUT) begin
            e.rspValid = 1'b1;
            e.rspError = 1'b1;
            e.rspData  = 32'hDEAD_BEEF;
            mPending   = 1'b0;
         end
`endif
      end
      e.ready = !mPending;
      expQ.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, RD, 32'h0, 32'h0, junkEmpty());
   endtask

   task automatic ring(input t_opcode op, input logic [31:0] a, input logic [31:0] d);
      step(1'b0, 1'b0, RD, 32'h0, 32'h0, mkPkt(1'b1, op, a, d));
   endtask

   task automatic host(input t_opcode op, input logic [31:0] a, input logic [31:0] d);
      step(1'b0, 1'b1, op, a, d, junkEmpty());
   endtask

   // -------------------------------------------------------------------------
   // Stimulus
   // -------------------------------------------------------------------------
   initial begin
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, RD, 32'h0, 32'h0, junkEmpty());
      idle(20);

      // WR on an empty ring, then its response.
      host(WR, 32'h0200_0001, 32'h0200_0001);
      idle(3);
      ring(WR_RSP, 32'h0200_0001, 32'h1234_5678);
      idle(2);

      // RD behind three foreign packets, then wrong-type/wrong-address
      // responses that must be forwarded, then the real answer.
      host(RD, 32'h0100_0010, 32'hFFFF_FFFF);
      ring(WR, 32'h0300_0004, 32'hA5A5_0001);
      ring(RD_RSP, 32'h0400_0008, 32'hA5A5_0002);
      ring(WR_RSP, 32'h0500_000C, 32'hA5A5_0003);
      idle(3);
      ring(RD_RSP, 32'h0100_0014, 32'h1111_2222);
      ring(WR_RSP, 32'h0100_0010, 32'h3333_4444);
      idle(2);
      ring(RD_RSP, 32'h0100_0010, 32'hCAFE_0001);
      idle(2);

      // Reset one cycle after injection drops the request.
      host(WR, 32'h0600_0020, 32'h0BAD_F00D);
      idle(1);
      step(1'b1, 1'b0, RD, 32'h0, 32'h0, junkEmpty());
      idle(2);
      ring(WR_RSP, 32'h0600_0020, 32'h0);
      idle(2);

`ifdef RING_HOST_MASTER_TIMEOUT_EN
      // No response at all, then a late one that must be forwarded.
      host(RD, 32'h0700_0040, 32'h0);
      idle(TB_TIMEOUT + 4);
      ring(RD_RSP, 32'h0700_0040, 32'h7777_7777);
      idle(2);
`endif

      // Randomized traffic with occasional matching responses and resets.
      for (int i = 0; i < 400; i++) begin
         t_ring_pkt   p;
         logic        hv;
         logic        r;
         t_opcode     op;
         logic [31:0] a;
         if ($urandom_range(0, 1) == 0)
            p = mkPkt(1'b1, t_opcode'($urandom_range(0, 3)),
                      {6'h0, 2'($urandom_range(0, 3)), 24'($urandom_range(0, 15))}, $urandom);
         else
            p = junkEmpty();
         if (mPending && mInjected && $urandom_range(0, 5) == 0)
            p = mkPkt(1'b1, (mOp == WR) ? WR_RSP : RD_RSP, mAddr, $urandom);
         hv = ($urandom_range(0, 3) == 0);
         r  = ($urandom_range(0, 99) == 0);
         op = ($urandom_range(0, 1) == 1) ? WR : RD;
         a  = {6'h0, 2'($urandom_range(0, 3)), 24'($urandom_range(0, 15))};
         step(r, hv, op, a, $urandom, p);
      end
      idle(2);

      @(negedge clk);
      #1;
      check("scoreboard_drained", 128'(expQ.size()), 128'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
